alu_seq: RTL and testbench

Parametrised, registered successor to the combinational alu32. It keeps the same 4-bit opcode map and Z/C/V/S flags, and adds a valid/ready handshake on both sides. ADD/SUB/logic/shift ops complete in one cycle. MUL and DIV run on an iterative shift-add / restoring-divide engine over WIDTH cycles, returning a full-width high word (product high half or remainder). The block sits between the operand fetch stage and result writeback.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_seq_muldiv.sv | 87 ++++++++
 rtl/alu_seq.sv | 193 +++++++++++++++++++
 tb/tb_alu_seq.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode map, FSM encoding and
// opcode classification helper.
package alu_pkg;

    localparam int OPW = 4;

    localparam logic [OPW-1:0] OP_ADD = 4'b0000;
    localparam logic [OPW-1:0] OP_SUB = 4'b0001;
    localparam logic [OPW-1:0] OP_AND = 4'b0010;
    localparam logic [OPW-1:0] OP_OR  = 4'b0011;
    localparam logic [OPW-1:0] OP_XOR = 4'b0100;
    localparam logic [OPW-1:0] OP_NOT = 4'b0101;
    localparam logic [OPW-1:0] OP_MUL = 4'b0110;
    localparam logic [OPW-1:0] OP_DIV = 4'b0111;
    localparam logic [OPW-1:0] OP_SHL = 4'b1000;
    localparam logic [OPW-1:0] OP_SHR = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic logic is_multicycle(input logic [OPW-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative multiply / restoring-divide engine: one bit per clock over WIDTH
// cycles, sharing one accumulator and one shift register between both ops.
module alu_seq_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);
    localparam int SHW = $clog2(WIDTH);

    logic             run_r;
    logic             div_r;
    logic [SHW-1:0]   cnt_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] mq_r;
    logic [WIDTH-1:0] opnd_r;

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   rem_s;
    logic [WIDTH:0]   trial_s;
    logic [WIDTH-1:0] acc_nxt_s;
    logic [WIDTH-1:0] mq_nxt_s;

    // One iteration step; lo/hi expose the post-step value so the caller can
    // capture the final result on the same edge as the last iteration.
    always_comb begin
        sum_s     = {1'b0, acc_r} + (mq_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
        rem_s     = {acc_r, mq_r[WIDTH-1]};
        trial_s   = rem_s - {1'b0, opnd_r};
        acc_nxt_s = acc_r;
        mq_nxt_s  = mq_r;
        if (div_r) begin
            if (!trial_s[WIDTH]) begin
                acc_nxt_s = trial_s[WIDTH-1:0];
                mq_nxt_s  = {mq_r[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt_s = rem_s[WIDTH-1:0];
                mq_nxt_s  = {mq_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_nxt_s = sum_s[WIDTH:1];
            mq_nxt_s  = {sum_s[0], mq_r[WIDTH-1:1]};
        end
    end

    assign done = run_r && (cnt_r == {SHW{1'b1}});
    assign lo   = mq_nxt_s;
    assign hi   = acc_nxt_s;

    // Operand load on start, then shift/accumulate until the counter wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_r  <= 1'b0;
            div_r  <= 1'b0;
            cnt_r  <= {SHW{1'b0}};
            acc_r  <= {WIDTH{1'b0}};
            mq_r   <= {WIDTH{1'b0}};
            opnd_r <= {WIDTH{1'b0}};
        end else if (start) begin
            run_r  <= 1'b1;
            div_r  <= is_div;
            cnt_r  <= {SHW{1'b0}};
            acc_r  <= {WIDTH{1'b0}};
            mq_r   <= a;
            opnd_r <= b;
        end else if (run_r) begin
            acc_r <= acc_nxt_s;
            mq_r  <= mq_nxt_s;
            cnt_r <= cnt_r + {{(SHW-1){1'b0}}, 1'b1};
            if (cnt_r == {SHW{1'b1}}) begin
                run_r <= 1'b0;
            end else begin
                run_r <= 1'b1;
            end
        end else begin
            run_r <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake on both sides; single-cycle ops
// are computed inline, MUL/DIV are delegated to the iterative engine.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             z,
    output logic             c,
    output logic             v,
    output logic             s,
    output logic             err
);
    state_t state_r, state_nxt_s;

    logic             in_ready_r, out_valid_r, is_div_r;
    logic [WIDTH-1:0] result_r, result_hi_r;
    logic             z_r, c_r, v_r, s_r, err_r;

    logic             multi_s, start_s, md_done_s;
    logic [WIDTH-1:0] md_lo_s, md_hi_s;
    logic [SHW-1:0]   shamt_s;
    logic [WIDTH:0]   wide_s;
    logic [WIDTH-1:0] sc_res_s, sc_hi_s;
    logic             sc_c_s, sc_v_s, sc_err_s;

    // DIV by zero is resolved immediately instead of running the engine.
    assign multi_s = is_multicycle(op) && !((op == OP_DIV) && (b == {WIDTH{1'b0}}));
    assign start_s = (state_r == ST_IDLE) && in_valid && multi_s;
    assign shamt_s = b[SHW-1:0];

    alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (start_s),
        .is_div (op == OP_DIV),
        .a      (a),
        .b      (b),
        .done   (md_done_s),
        .lo     (md_lo_s),
        .hi     (md_hi_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nxt_s = multi_s ? ST_BUSY : ST_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (md_done_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Single-cycle datapath; shifts carry one spare bit to catch the last bit out.
    always_comb begin
        wide_s   = {(WIDTH+1){1'b0}};
        sc_res_s = {WIDTH{1'b0}};
        sc_hi_s  = {WIDTH{1'b0}};
        sc_c_s   = 1'b0;
        sc_v_s   = 1'b0;
        sc_err_s = 1'b0;
        case (op)
            OP_ADD: begin
                wide_s   = {1'b0, a} + {1'b0, b};
                sc_res_s = wide_s[WIDTH-1:0];
                sc_c_s   = wide_s[WIDTH];
                sc_v_s   = (a[WIDTH-1] == b[WIDTH-1]) && (wide_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                wide_s   = {1'b0, a} - {1'b0, b};
                sc_res_s = wide_s[WIDTH-1:0];
                sc_c_s   = wide_s[WIDTH];
                sc_v_s   = (a[WIDTH-1] != b[WIDTH-1]) && (wide_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: sc_res_s = a & b;
            OP_OR:  sc_res_s = a | b;
            OP_XOR: sc_res_s = a ^ b;
            OP_NOT: sc_res_s = ~a;
            OP_MUL: sc_res_s = {WIDTH{1'b0}};
            OP_DIV: begin
                if (b == {WIDTH{1'b0}}) begin
                    sc_res_s = {WIDTH{1'b1}};
                    sc_hi_s  = a;
                    sc_err_s = 1'b1;
                    sc_v_s   = 1'b1;
                end else begin
                    sc_res_s = {WIDTH{1'b0}};
                end
            end
            OP_SHL: begin
                wide_s   = {1'b0, a} << shamt_s;
                sc_res_s = wide_s[WIDTH-1:0];
                sc_c_s   = wide_s[WIDTH];
            end
            OP_SHR: begin
                wide_s   = {a, 1'b0} >> shamt_s;
                sc_res_s = wide_s[WIDTH:1];
                sc_c_s   = wide_s[0];
            end
            default: sc_err_s = 1'b1;
        endcase
    end

    // Output registers: loaded only on entry to DONE, held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            is_div_r    <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            result_hi_r <= {WIDTH{1'b0}};
            z_r         <= 1'b0;
            c_r         <= 1'b0;
            v_r         <= 1'b0;
            s_r         <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            in_ready_r  <= (state_nxt_s == ST_IDLE);
            out_valid_r <= (state_nxt_s == ST_DONE);
            if (start_s) begin
                is_div_r <= (op == OP_DIV);
            end
            if ((state_r == ST_IDLE) && in_valid && !multi_s) begin
                result_r    <= sc_res_s;
                result_hi_r <= sc_hi_s;
                z_r         <= (sc_res_s == {WIDTH{1'b0}});
                c_r         <= sc_c_s;
                v_r         <= sc_v_s;
                s_r         <= sc_res_s[WIDTH-1];
                err_r       <= sc_err_s;
            end else if ((state_r == ST_BUSY) && md_done_s) begin
                result_r    <= md_lo_s;
                result_hi_r <= md_hi_s;
                z_r         <= (md_lo_s == {WIDTH{1'b0}});
                c_r         <= is_div_r ? 1'b0 : (md_hi_s != {WIDTH{1'b0}});
                v_r         <= is_div_r ? 1'b0 : (md_hi_s != {WIDTH{1'b0}});
                s_r         <= md_lo_s[WIDTH-1];
                err_r       <= 1'b0;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign result_hi = result_hi_r;
    assign z         = z_r;
    assign c         = c_r;
    assign v         = v_r;
    assign s         = s_r;
    assign err       = err_r;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases, randomized ops against an
// arithmetic reference model, backpressure, throughput and mid-op reset.
module tb_alu_seq;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, result, result_hi;
    logic [3:0]  op;
    logic        z, c, v, s, err;
    int          checks = 0;
    int          errors = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_hi(result_hi),
        .z(z), .c(c), .v(v), .s(s), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model: flags f = {z,c,v,s,err}; lat = edges from presenting the op to out_valid.
    function automatic void model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [31:0] h,
                                  output logic [4:0] f, output int lat);
        longint      sx, sy, sr;
        logic [63:0] p;
        int          n;
        logic        cc, vv, ee;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r = 32'd0; h = 32'd0; cc = 1'b0; vv = 1'b0; ee = 1'b0; lat = 1;
        n = int'(y[4:0]);
        case (o)
            4'h0: begin
                p = {32'd0, x} + {32'd0, y};
                r = p[31:0]; cc = p[32];
                sr = sx + sy; vv = (sr != longint'($signed(r)));
            end
            4'h1: begin
                r = x - y; cc = (x < y);
                sr = sx - sy; vv = (sr != longint'($signed(r)));
            end
            4'h2: r = x & y;
            4'h3: r = x | y;
            4'h4: r = x ^ y;
            4'h5: r = ~x;
            4'h6: begin
                p = {32'd0, x} * {32'd0, y};
                r = p[31:0]; h = p[63:32]; cc = (h != 32'd0); vv = cc; lat = 33;
            end
            4'h7: begin
                if (y == 32'd0) begin
                    r = 32'hFFFF_FFFF; h = x; ee = 1'b1; vv = 1'b1;
                end else begin
                    r = x / y; h = x % y; lat = 33;
                end
            end
            4'h8: begin r = x << n; cc = (n == 0) ? 1'b0 : x[32-n]; end
            4'h9: begin r = x >> n; cc = (n == 0) ? 1'b0 : x[n-1]; end
            default: ee = 1'b1;
        endcase
        f = {(r == 32'd0), cc, vv, r[31], ee};
    endfunction

    // Present one op (DUT idle, out_ready=1), wait for out_valid, capture, return to IDLE.
    task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output logic [31:0] h,
                         output logic [4:0] f, output int lat);
        op = o; a = x; b = y; in_valid = 1'b1; lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            in_valid = 1'b0;
        end while (!out_valid && lat < 100);
        r = result; h = result_hi; f = {z, c, v, s, err};
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++; $display("FAIL reset_handshake: got %b required 10", {in_ready, out_valid});
        end
        checks++;
        if ({result, result_hi, z, c, v, s, err} !== 69'd0) begin
            errors++; $display("FAIL reset_outputs: got %h/%h %b required zero", result, result_hi, {z, c, v, s, err});
        end
    endtask

    task automatic test_directed();
        logic [3:0]  ops [9] = '{4'h0, 4'h1, 4'h6, 4'h7, 4'h7, 4'h8, 4'h9, 4'h8, 4'hF};
        logic [31:0] xs  [9] = '{32'hFFFF_FFFF, 32'd4, 32'h0001_0000, 32'd7, 32'd5,
                                 32'h8000_0001, 32'h8000_0000, 32'h1234_5678, 32'hDEAD_BEEF};
        logic [31:0] ys  [9] = '{32'd1, 32'd5, 32'h0001_0000, 32'd2, 32'd0,
                                 32'd1, 32'd31, 32'd0, 32'h0000_1234};
        logic [31:0] r, h, er, eh;
        logic [4:0]  f, ef;
        int          lat, el;
        for (int i = 0; i < 9; i++) begin
            model(ops[i], xs[i], ys[i], er, eh, ef, el);
            do_op(ops[i], xs[i], ys[i], r, h, f, lat);
            checks++;
            if (r !== er) begin errors++; $display("FAIL dir%0d result: got %h required %h", i, r, er); end
            checks++;
            if (h !== eh) begin errors++; $display("FAIL dir%0d result_hi: got %h required %h", i, h, eh); end
            checks++;
            if (f !== ef) begin errors++; $display("FAIL dir%0d flags zcvse: got %b required %b", i, f, ef); end
            checks++;
            if (lat !== el) begin errors++; $display("FAIL dir%0d latency: got %0d required %0d", i, lat, el); end
        end
    endtask

    task automatic test_random();
        logic [3:0]  o;
        logic [31:0] x, y, r, h, er, eh;
        logic [4:0]  f, ef;
        int          lat, el;
        for (int i = 0; i < 80; i++) begin
            o = 4'($urandom_range(0, 15));
            x = $urandom;
            y = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            if ($urandom_range(0, 9) == 0) y = 32'd0;
            model(o, x, y, er, eh, ef, el);
            do_op(o, x, y, r, h, f, lat);
            checks++;
            if ({r, h} !== {er, eh}) begin
                errors++; $display("FAIL rnd%0d op%h %h,%h: got %h/%h required %h/%h", i, o, x, y, r, h, er, eh);
            end
            checks++;
            if (f !== ef) begin errors++; $display("FAIL rnd%0d op%h flags: got %b required %b", i, o, f, ef); end
            checks++;
            if (lat !== el) begin errors++; $display("FAIL rnd%0d op%h latency: got %0d required %0d", i, o, lat, el); end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        op = 4'h0; a = 32'd3; b = 32'd2; in_valid = 1'b1;
        @(posedge clk); #1;
        op = 4'h1; a = 32'd9; b = 32'd1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({out_valid, in_ready, result} !== {1'b1, 1'b0, 32'd5}) begin
                errors++; $display("FAIL backpressure_hold%0d: got valid=%b ready=%b result=%h required 1 0 5",
                                   i, out_valid, in_ready, result);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, in_ready, result} !== {1'b0, 1'b1, 32'd5}) begin
            errors++; $display("FAIL backpressure_release: got valid=%b ready=%b result=%h required 0 1 5",
                               out_valid, in_ready, result);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] x, y;
        int          n_out = 0;
        x = $urandom; y = $urandom;
        op = 4'h0; a = x; b = y; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                n_out++;
                checks++;
                if (result !== x + y) begin errors++; $display("FAIL b2b_result: got %h required %h", result, x + y); end
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (n_out !== 5) begin errors++; $display("FAIL b2b_throughput: got %0d results required 5", n_out); end
    endtask

    task automatic test_reset_mid_busy();
        logic [31:0] r, h;
        logic [4:0]  f;
        int          lat;
        op = 4'h6; a = $urandom; b = $urandom; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, in_ready, result} !== {1'b0, 1'b1, 32'd0}) begin
            errors++; $display("FAIL midbusy_reset: got valid=%b ready=%b result=%h required 0 1 0",
                               out_valid, in_ready, result);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        do_op(4'h0, 32'd1, 32'd2, r, h, f, lat);
        checks++;
        if ({r, lat} !== {32'd3, 32'd1}) begin
            errors++; $display("FAIL post_reset_add: got result=%h lat=%0d required 3 1", r, lat);
        end
        do_op(4'hF, 32'h5555_AAAA, 32'd7, r, h, f, lat);
        checks++;
        if ({r, h, f} !== {32'd0, 32'd0, 5'b10001}) begin
            errors++; $display("FAIL illegal_op: got %h/%h flags=%b required 0/0 10001", r, h, f);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = 32'd0; b = 32'd0; op = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
